// File: rtl/mul_mod_pkg.sv
// Shared types and helpers for the mul_mod sequential modular multiplier.
package mul_mod_pkg;

  localparam int WIDTH_DEF = 128;
  localparam int CNT_W     = $clog2(WIDTH_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // (x + y) mod m for x, y < m; the extra bit keeps the sum from wrapping when m is near 2^WIDTH.
  function automatic logic [WIDTH_DEF-1:0] modadd(input logic [WIDTH_DEF-1:0] x,
                                                  input logic [WIDTH_DEF-1:0] y,
                                                  input logic [WIDTH_DEF-1:0] m);
    logic [WIDTH_DEF:0] sum;
    sum = {1'b0, x} + {1'b0, y};
    if (sum >= {1'b0, m}) sum = sum - {1'b0, m};
    return sum[WIDTH_DEF-1:0];
  endfunction

endpackage

// File: rtl/mul_mod_if.sv
// Request/response bundle between a client and the mul_mod multiplier.
interface mul_mod_if #(parameter int WIDTH = mul_mod_pkg::WIDTH_DEF);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] res;
  logic             busy;
  logic             valid;
  logic             err;

  modport master (output start, a, b, m, input res, busy, valid, err);
  modport slave  (input start, a, b, m, output res, busy, valid, err);

endinterface

// File: rtl/mul_mod_step.sv
// One MSB-first step of interleaved modular multiplication: acc*2 (+a) mod m.
module mod_step #(
  parameter int WIDTH = 128
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] m,
  input  logic             bit_b,
  output logic [WIDTH-1:0] s
);

  logic [WIDTH:0]   mx;
  logic [WIDTH:0]   d2;
  logic [WIDTH-1:0] d;
  logic [WIDTH:0]   s2;

  always_comb begin
    mx = {1'b0, m};
    d2 = {acc, 1'b0};
    d  = (d2 >= mx) ? WIDTH'(d2 - mx) : WIDTH'(d2);
    s2 = {1'b0, d} + {1'b0, a};
    if (bit_b) begin
      s = (s2 >= mx) ? WIDTH'(s2 - mx) : WIDTH'(s2);
    end else begin
      s = d;
    end
  end

endmodule

// File: rtl/mul_mod.sv
// Sequential modular multiplier res = a*b mod m, one bit of b per cycle, MSB first.
// Optional operand range check is built when MUL_MOD_RANGE_CHECK_EN is defined.
//   state | meaning
//   IDLE  | waiting for start; res/valid hold the last result
//   RUN   | stepping through b, cnt = bit index being consumed
module mul_mod
  import mul_mod_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic     clk,
  input logic     rst_n,
  mul_mod_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, m_q, acc, res_q;
  logic [WIDTH-1:0] a_nxt, b_nxt, m_nxt, acc_nxt, res_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             busy_q, busy_nxt, valid_q, valid_nxt;
  logic [WIDTH-1:0] step;
  logic             accept;
  logic             skip;

  assign accept = (state == IDLE) && bus.start;

  mod_step #(.WIDTH(WIDTH)) u_step (
    .acc   (acc),
    .a     (a_q),
    .m     (m_q),
    .bit_b (b_q[cnt]),
    .s     (step)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      acc     <= '0;
      cnt     <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      a_q     <= a_nxt;
      b_q     <= b_nxt;
      m_q     <= m_nxt;
      acc     <= acc_nxt;
      cnt     <= cnt_nxt;
      res_q   <= res_nxt;
      busy_q  <= busy_nxt;
      valid_q <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    a_nxt     = a_q;
    b_nxt     = b_q;
    m_nxt     = m_q;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    res_nxt   = res_q;
    busy_nxt  = busy_q;
    valid_nxt = valid_q;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          a_nxt     = bus.a;
          b_nxt     = bus.b;
          m_nxt     = bus.m;
          acc_nxt   = '0;
          cnt_nxt   = CW'(WIDTH - 1);
          valid_nxt = 1'b0;
          busy_nxt  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (skip) begin
          // Rejected operands: finish immediately with a zero result.
          res_nxt   = '0;
          valid_nxt = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          acc_nxt = step;
          cnt_nxt = cnt - CW'(1);
          if (cnt == '0) begin
            res_nxt   = step;
            valid_nxt = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MUL_MOD_RANGE_CHECK_EN
  logic err_q, bad_q, range_bad;

  assign range_bad = (bus.a >= bus.m) || (bus.b >= bus.m) || (bus.m < WIDTH'(2));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      bad_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
      bad_q <= range_bad;
    end else if (state == RUN && bad_q) begin
      err_q <= 1'b1;
      bad_q <= 1'b0;
    end
  end

  assign skip    = bad_q;
  assign bus.err = err_q;
`else
  assign skip    = 1'b0;
  assign bus.err = 1'b0;
`endif

  assign bus.res   = res_q;
  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;

endmodule
